alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Parametrised operand-select pipeline stage between register-file read and the ALU in the teaching CPU datapath.
- Latches operand A from rd_q and selects operand B from one of four sources: zero-extended immediate, rs_q, ldr_offset, or sign-extended immediate.
- Uses valid/ready handshakes on both sides with a one-entry skid buffer, so the ALU can stall without losing or duplicating an operation.
- Adds an optional A/B swap for reverse-operand instructions.

Parameters:
- DATA_W, 16: width of rd_q, rs_q, ldr_offset, alu_a and alu_b.
- OFFSET_W, 8: width of the immediate field offset. Must satisfy 1 <= OFFSET_W <= DATA_W; otherwise elaboration fails.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents an operation this cycle.
- in_ready  output  1  stage can accept an operation this cycle.
- rd_q  input  DATA_W  register-file read port for rd; source of operand A.
- rs_q  input  DATA_W  register-file read port for rs.
- ldr_offset  input  DATA_W  precomputed load/store offset.
- offset  input  OFFSET_W  instruction immediate field.
- alu_in_sel  input  2  operand-B source: 00 zero-extended offset, 01 rs_q, 10 ldr_offset, 11 sign-extended offset.
- swap  input  1  when 1, the selected B value drives alu_a and rd_q drives alu_b.
- out_valid  output  1  alu_a and alu_b hold a valid operation.
- out_ready  input  1  ALU accepts the operation this cycle.
- alu_a  output  DATA_W  operand A to the ALU (registered).
- alu_b  output  DATA_W  operand B to the ALU (registered).

Behaviour:
- Reset (asynchronous, rst=1):
  - out_valid=0, alu_a=0, alu_b=0.
  - Skid entry empty with its data cleared to 0.
  - in_ready=1.
  - Reset asserted mid-operation discards both the output entry and the skid entry; nothing is replayed after release.
- Handshake rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = ~skid_valid, taken directly from a register with no combinational path from out_ready.
  - in_valid is ignored while in_ready=0; the stage never samples the inputs in that case.
- Operand formation happens at the input transfer cycle using that cycle's input values:
  - B source 00: offset zero-extended to DATA_W.
  - B source 01: rs_q.
  - B source 10: ldr_offset.
  - B source 11: offset sign-extended (MSB replicated) to DATA_W.
  - When OFFSET_W == DATA_W, zero- and sign-extension both pass offset through unchanged.
  - swap=0 gives pair {A=rd_q, B=sel}; swap=1 gives {A=sel, B=rd_q}.
  - The pair is captured whole. Later changes on the inputs do not affect it.
- Output register (out_valid, alu_a, alu_b) load rule, evaluated each clock:
  - Load is allowed when out_valid=0, or when out_valid=1 and out_ready=1.
  - If the skid entry is valid, the output loads from the skid entry and the skid entry empties. An input transfer is impossible that cycle because in_ready=0.
  - Else, if an input transfer occurs, the output loads the newly formed pair with out_valid=1.
  - Else, out_valid goes to 0. alu_a and alu_b keep their previous values and are don't-care while out_valid=0.
  - If load is not allowed (out_valid=1, out_ready=0) and an input transfer occurs, the new pair goes into the skid entry, skid_valid=1, and in_ready drops the next cycle.
- Latency and throughput:
  - 1 cycle from input transfer to out_valid when the output register is free.
  - Full throughput: one operation per cycle while out_ready=1.
  - Operations leave in strict arrival order. No drops, no duplicates.
- While out_valid=1 and out_ready=0, alu_a, alu_b and out_valid hold stable.
- Occupancy is at most 2 (output entry plus skid entry). When both are full: in_ready=0, out_valid=1.
- When full and out_ready rises: the output takes the skid entry in that same cycle, and in_ready=1 on the next cycle.

Test Plan:
- Reset during traffic: assert rst while both entries are full -> out_valid=0, alu_a=alu_b=0, in_ready=1 immediately (asynchronous); after release, no stale operation appears.
- Source select (DATA_W=16, OFFSET_W=8), one op per cycle with out_ready=1, rd_q=16'h1234, rs_q=16'h00AA, ldr_offset=16'h0F0F, offset=8'hF0:
  - sel 00 -> alu_b=16'h00F0.
  - sel 01 -> alu_b=16'h00AA.
  - sel 10 -> alu_b=16'h0F0F.
  - sel 11 -> alu_b=16'hFFF0.
  - In every case alu_a=16'h1234, with each result one cycle after its transfer.
- Swap: rd_q=16'h0005, sel 01, rs_q=16'h0009, swap=1 -> alu_a=16'h0009, alu_b=16'h0005.
- Backpressure: out_ready=0 while three ops with rd_q = 1, 2, 3 are offered back-to-back ->
  - op1 is held in the output, op2 goes to skid, in_ready=0, op3 is stalled.
  - Raising out_ready yields rd-derived alu_a sequence 1, 2, 3 with no gaps or duplicates.
- Simultaneous in/out transfer at occupancy 1 with out_ready=1 every cycle and in_valid=1 for 8 cycles -> 8 outputs on 8 consecutive cycles, in_ready stays 1 throughout.
- Parameter corner (DATA_W=8, OFFSET_W=8): offset=8'h80 with sel 00 and with sel 11 -> alu_b=8'h80 in both cases. Random valid/ready stress against a FIFO scoreboard -> zero mismatches.

Source files
------------

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : Operand-select stage between register-file read and the ALU,
//            with valid/ready handshakes and a one-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int DATA_W   = 16,
  parameter int OFFSET_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   rd_q,
  input  logic [DATA_W-1:0]   rs_q,
  input  logic [DATA_W-1:0]   ldr_offset,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [1:0]          alu_in_sel,
  input  logic                swap,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b
);

  localparam logic [1:0] c_SEL_ZEXT = 2'b00;
  localparam logic [1:0] c_SEL_RS   = 2'b01;
  localparam logic [1:0] c_SEL_LDR  = 2'b10;

  if (OFFSET_W < 1 || OFFSET_W > DATA_W) begin : g_bad_offset_w
    $error("alu_operand_stage: OFFSET_W must satisfy 1 <= OFFSET_W <= DATA_W");
  end

  logic [DATA_W-1:0] w_offset_zext;
  logic [DATA_W-1:0] w_offset_sext;
  logic [DATA_W-1:0] w_sel_b;
  logic [DATA_W-1:0] w_pair_a;
  logic [DATA_W-1:0] w_pair_b;
  logic              w_in_fire;
  logic              w_out_load;

  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_a;
  logic [DATA_W-1:0] r_skid_b;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;

  // A full-width immediate needs no padding, so both extensions collapse to a pass-through.
  if (OFFSET_W == DATA_W) begin : g_ext_full
    assign w_offset_zext = offset;
    assign w_offset_sext = offset;
  end else begin : g_ext_pad
    assign w_offset_zext = {{(DATA_W-OFFSET_W){1'b0}}, offset};
    assign w_offset_sext = {{(DATA_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  end

  always_comb begin
    w_sel_b = w_offset_sext;
    case (alu_in_sel)
      c_SEL_ZEXT: w_sel_b = w_offset_zext;
      c_SEL_RS:   w_sel_b = rs_q;
      c_SEL_LDR:  w_sel_b = ldr_offset;
      default:    w_sel_b = w_offset_sext;
    endcase
  end

  assign w_pair_a   = swap ? w_sel_b : rd_q;
  assign w_pair_b   = swap ? rd_q    : w_sel_b;
  assign w_in_fire  = in_valid & ~r_skid_valid;
  assign w_out_load = ~r_out_valid | out_ready;

  // The skid entry always holds the older operation, so it drains before new input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_valid <= 1'b0;
      r_skid_a     <= '0;
      r_skid_b     <= '0;
      r_out_valid  <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
    end else if (w_out_load) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_alu_a      <= r_skid_a;
        r_alu_b      <= r_skid_b;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out_valid  <= 1'b1;
        r_alu_a      <= w_pair_a;
        r_alu_b      <= w_pair_b;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_a     <= w_pair_a;
      r_skid_b     <= w_pair_b;
    end
  end

  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_out_valid;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Directed and randomized self-checking bench for alu_operand_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rd_q;
  logic [15:0] rs_q;
  logic [15:0] ldr_offset;
  logic [7:0]  offset;
  logic [1:0]  alu_in_sel;
  logic        swap;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  rd_q8;
  logic [7:0]  rs_q8;
  logic [7:0]  ldr_offset8;
  logic [7:0]  offset8;
  logic [1:0]  alu_in_sel8;
  logic        out_valid8;
  logic [7:0]  alu_a8;
  logic [7:0]  alu_b8;

  int checks;
  int failures;

  alu_operand_stage #(.DATA_W(16), .OFFSET_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rd_q       (rd_q),
    .rs_q       (rs_q),
    .ldr_offset (ldr_offset),
    .offset     (offset),
    .alu_in_sel (alu_in_sel),
    .swap       (swap),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b)
  );

  alu_operand_stage #(.DATA_W(8), .OFFSET_W(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .rd_q       (rd_q8),
    .rs_q       (rs_q8),
    .ldr_offset (ldr_offset8),
    .offset     (offset8),
    .alu_in_sel (alu_in_sel8),
    .swap       (1'b0),
    .out_valid  (out_valid8),
    .out_ready  (1'b1),
    .alu_a      (alu_a8),
    .alu_b      (alu_b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_a !== 16'h0000 || alu_b !== 16'h0000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got v=%b a=%h b=%h rdy=%b, want v=0 a=0000 b=0000 rdy=1",
               out_valid, alu_a, alu_b, in_ready);
    end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_select();
    logic [15:0] exp_b [4];
    exp_b[0] = 16'h00F0;
    exp_b[1] = 16'h00AA;
    exp_b[2] = 16'h0F0F;
    exp_b[3] = 16'hFFF0;
    out_ready  = 1'b1;
    rd_q       = 16'h1234;
    rs_q       = 16'h00AA;
    ldr_offset = 16'h0F0F;
    offset     = 8'hF0;
    swap       = 1'b0;
    in_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_in_sel = 2'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || alu_a !== 16'h1234 || alu_b !== exp_b[i]) begin
        failures++;
        $display("FAIL select_%0d: got v=%b a=%h b=%h, want v=1 a=1234 b=%h",
                 i, out_valid, alu_a, alu_b, exp_b[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL select_drain: got v=%b, want v=0", out_valid);
    end
  endtask

  task automatic test_swap();
    out_ready  = 1'b1;
    rd_q       = 16'h0005;
    rs_q       = 16'h0009;
    alu_in_sel = 2'b01;
    swap       = 1'b1;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    swap     = 1'b0;
    rs_q     = 16'h7777;
    rd_q     = 16'h6666;
    checks++;
    if (out_valid !== 1'b1 || alu_a !== 16'h0009 || alu_b !== 16'h0005) begin
      failures++;
      $display("FAIL swap: got v=%b a=%h b=%h, want v=1 a=0009 b=0005", out_valid, alu_a, alu_b);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready  = 1'b0;
    alu_in_sel = 2'b01;
    swap       = 1'b0;
    in_valid   = 1'b1;
    rd_q = 16'd1; rs_q = 16'h0101;
    step();
    rd_q = 16'd2; rs_q = 16'h0102;
    step();
    rd_q = 16'd3; rs_q = 16'h0103;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_a !== 16'd1 || alu_b !== 16'h0101) begin
      failures++;
      $display("FAIL bp_full: got rdy=%b v=%b a=%h b=%h, want rdy=0 v=1 a=0001 b=0101",
               in_ready, out_valid, alu_a, alu_b);
    end
    step();
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_a !== 16'd1 || alu_b !== 16'h0101) begin
      failures++;
      $display("FAIL bp_hold: got rdy=%b v=%b a=%h b=%h, want rdy=0 v=1 a=0001 b=0101",
               in_ready, out_valid, alu_a, alu_b);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || alu_a !== 16'd2 || alu_b !== 16'h0102 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain2: got v=%b a=%h b=%h rdy=%b, want v=1 a=0002 b=0102 rdy=1",
               out_valid, alu_a, alu_b, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_a !== 16'd3 || alu_b !== 16'h0103) begin
      failures++;
      $display("FAIL bp_drain3: got v=%b a=%h b=%h, want v=1 a=0003 b=0103",
               out_valid, alu_a, alu_b);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_dup: got v=%b a=%h, want v=0", out_valid, alu_a);
    end
  endtask

  task automatic test_back_to_back();
    out_ready  = 1'b1;
    alu_in_sel = 2'b10;
    swap       = 1'b0;
    in_valid   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_q       = 16'h0010 + 16'(i);
      ldr_offset = 16'hA000 + 16'(i);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready_%0d: got rdy=%b, want 1", i, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || alu_a !== 16'h0010 + 16'(i) || alu_b !== 16'hA000 + 16'(i)) begin
        failures++;
        $display("FAIL b2b_out_%0d: got v=%b a=%h b=%h, want v=1 a=%h b=%h",
                 i, out_valid, alu_a, alu_b, 16'h0010 + 16'(i), 16'hA000 + 16'(i));
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_traffic();
    out_ready  = 1'b0;
    alu_in_sel = 2'b01;
    in_valid   = 1'b1;
    rd_q = 16'h00C1; rs_q = 16'h00D1;
    step();
    rd_q = 16'h00C2; rs_q = 16'h00D2;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_fill: got rdy=%b v=%b, want rdy=0 v=1", in_ready, out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_a !== 16'h0000 || alu_b !== 16'h0000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_async: got v=%b a=%h b=%h rdy=%b, want v=0 a=0000 b=0000 rdy=1",
               out_valid, alu_a, alu_b, in_ready);
    end
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL rst_no_replay_%0d: got v=%b rdy=%b a=%h, want v=0 rdy=1",
                 i, out_valid, in_ready, alu_a);
      end
    end
  endtask

  task automatic test_corner8();
    rd_q8       = 8'h11;
    rs_q8       = 8'h22;
    ldr_offset8 = 8'h33;
    offset8     = 8'h80;
    in_valid8   = 1'b1;
    alu_in_sel8 = 2'b00;
    step();
    checks++;
    if (out_valid8 !== 1'b1 || alu_a8 !== 8'h11 || alu_b8 !== 8'h80) begin
      failures++;
      $display("FAIL corner8_zext: got v=%b a=%h b=%h, want v=1 a=11 b=80", out_valid8, alu_a8, alu_b8);
    end
    alu_in_sel8 = 2'b11;
    step();
    in_valid8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b1 || alu_a8 !== 8'h11 || alu_b8 !== 8'h80) begin
      failures++;
      $display("FAIL corner8_sext: got v=%b a=%h b=%h, want v=1 a=11 b=80", out_valid8, alu_a8, alu_b8);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [15:0] sel_v;
    logic [31:0] head;
    int          n_pop;
    n_pop = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid   = (cyc < 360) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready  = (cyc < 360) ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_q       = 16'($urandom);
      rs_q       = 16'($urandom);
      ldr_offset = 16'($urandom);
      offset     = 8'($urandom);
      alu_in_sel = 2'($urandom_range(0, 3));
      swap       = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra_%0d: got a=%h b=%h, want no output", cyc, alu_a, alu_b);
        end else begin
          head = q.pop_front();
          n_pop++;
          if ({alu_a, alu_b} !== head) begin
            failures++;
            $display("FAIL rand_data_%0d: got a=%h b=%h, want a=%h b=%h",
                     cyc, alu_a, alu_b, head[31:16], head[15:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        case (alu_in_sel)
          2'b00:   sel_v = {8'h00, offset};
          2'b01:   sel_v = rs_q;
          2'b10:   sel_v = ldr_offset;
          default: sel_v = {{8{offset[7]}}, offset};
        endcase
        q.push_back(swap ? {sel_v, rd_q} : {rd_q, sel_v});
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain: got pending=%0d v=%b, want pending=0 v=0", q.size(), out_valid);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    in_valid    = 1'b0;
    rd_q        = '0;
    rs_q        = '0;
    ldr_offset  = '0;
    offset      = '0;
    alu_in_sel  = '0;
    swap        = 1'b0;
    out_ready   = 1'b0;
    in_valid8   = 1'b0;
    rd_q8       = '0;
    rs_q8       = '0;
    ldr_offset8 = '0;
    offset8     = '0;
    alu_in_sel8 = '0;
    #2;
    test_reset();
    test_select();
    test_swap();
    test_backpressure();
    test_back_to_back();
    test_reset_traffic();
    test_corner8();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
